// File: rtl/mlm_dec.sv
// Hamming SEC decoder/corrector for 16 data bits and 5 parity bits.
// Stage 1 registers the received word and its syndrome. Stage 2 registers the
// corrected word and the error flags. Saturating counters track how many
// delivered words were corrected and how many were uncorrectable.
module mlm_dec #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:15]      in_data,
  input  logic [0:4]       in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:15]      out_data,
  output logic [4:0]       out_syn,
  output logic             out_corr,
  output logic             out_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // Codeword position of each data bit d[i]; parity bit p[k] sits at 2**k.
  localparam logic [4:0] DataPos [16] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  logic             en;
  logic             s1_valid_q, s1_valid_d;
  logic [0:15]      s1_data_q, s1_data_d;
  logic [4:0]       s1_syn_q, s1_syn_d;
  logic             out_valid_q, out_valid_d;
  logic [0:15]      out_data_q, out_data_d;
  logic [4:0]       out_syn_q, out_syn_d;
  logic             out_corr_q, out_corr_d;
  logic             out_uncorr_q, out_uncorr_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
  logic             out_xfer;

  // Global pipeline advance: everything moves together or everything holds.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign out_xfer = out_valid_q && out_ready;

  // Stage 1: XOR of the positions of all set data bits is exactly the
  // recomputed parity vector, so the syndrome is that XOR against p[].
  always_comb begin
    logic [4:0] calc;
    logic [4:0] par_vec;
    calc    = '0;
    par_vec = '0;
    for (int i = 0; i < 16; i++) begin
      if (in_data[i]) calc = calc ^ DataPos[i];
    end
    for (int k = 0; k < 5; k++) begin
      par_vec[k] = in_par[k];
    end
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_syn_d  = calc ^ par_vec;
      end
    end
  end

  // Stage 2: flip the data bit named by the syndrome and classify it.
  always_comb begin
    logic [0:15] fixed;
    logic        unc;
    fixed = s1_data_q;
    for (int i = 0; i < 16; i++) begin
      if (s1_syn_q == DataPos[i]) fixed[i] = ~fixed[i];
    end
    unc          = (s1_syn_q >= 5'd22);
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = unc ? s1_data_q : fixed;
        out_syn_d    = s1_syn_q;
        out_corr_d   = (s1_syn_q != 5'd0) && !unc;
        out_uncorr_d = unc;
      end
    end
  end

  // Saturating event counters; a clear wins over a same-cycle event.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_xfer) begin
      if (out_corr_q && corr_cnt_q != '1)     corr_cnt_d   = corr_cnt_q + 1'b1;
      if (out_uncorr_q && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_syn    = out_syn_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_mlm_dec.sv
// Directed bench for mlm_dec, built with 2-bit counters so saturation is reachable.
module tb_mlm_dec;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [0:15]   in_data;
  logic [0:4]    in_par;
  logic          out_valid;
  logic          out_ready;
  logic [0:15]   out_data;
  logic [4:0]    out_syn;
  logic          out_corr;
  logic          out_uncorr;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  int passed = 0;
  int total  = 0;

  mlm_dec #(.CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_syn   (out_syn),
    .out_corr  (out_corr),
    .out_uncorr(out_uncorr),
    .cnt_clr   (cnt_clr),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, then wait until it sits on the output (not yet consumed).
  task automatic send(input logic [0:15] d, input logic [0:4] p);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  // Clean stream words: parity vectors written as p[0..4] left to right.
  logic [0:15] wd [6];
  logic [0:4]  wp [6];
  logic [0:4]  pv;
  logic [0:15] held;
  int          tx;
  int          rx;

  initial begin
    wd[0] = 16'h0001; wp[0] = 5'b10101;
    wd[1] = 16'h8000; wp[1] = 5'b11000;
    wd[2] = 16'h0800; wp[2] = 5'b10010;
    wd[3] = 16'h8800; wp[3] = 5'b01010;
    wd[4] = 16'h8801; wp[4] = 5'b11111;
    wd[5] = 16'h0000; wp[5] = 5'b00000;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_syn", 32'(out_syn), 32'd0);
    chk("rst_flags", {30'd0, out_corr, out_uncorr}, 32'd0);
    chk("rst_cnts", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: all-zero clean word.
    send(16'h0000, 5'b00000);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h0000);
    chk("t1_syn", 32'(out_syn), 32'd0);
    chk("t1_flags", {30'd0, out_corr, out_uncorr}, 32'd0);
    tick();

    // 2: d0 flipped -> syndrome 3, corrected back to zero.
    send(16'h8000, 5'b00000);
    chk("t2_syn", 32'(out_syn), 32'd3);
    chk("t2_data", 32'(out_data), 32'h0000);
    chk("t2_flags", {30'd0, out_corr, out_uncorr}, 32'b10);
    tick();
    chk("t2_corr_cnt", 32'(corr_cnt), 32'd1);

    // 3: d15 with its correct parity, then the same word with p[0] flipped.
    send(16'h0001, 5'b10101);
    chk("t3a_syn", 32'(out_syn), 32'd0);
    chk("t3a_data", 32'(out_data), 32'h0001);
    chk("t3a_corr", 32'(out_corr), 32'd0);
    tick();
    pv = 5'b10101;
    pv[0] = ~pv[0];
    send(16'h0001, pv);
    chk("t3b_syn", 32'(out_syn), 32'd1);
    chk("t3b_data", 32'(out_data), 32'h0001);
    chk("t3b_corr", 32'(out_corr), 32'd1);
    tick();
    chk("t3b_corr_cnt", 32'(corr_cnt), 32'd2);

    // 4: all parity bits wrong -> syndrome 31, uncorrectable.
    send(16'h0000, 5'b11111);
    chk("t4_syn", 32'(out_syn), 32'd31);
    chk("t4_flags", {30'd0, out_corr, out_uncorr}, 32'b01);
    chk("t4_data", 32'(out_data), 32'h0000);
    tick();
    chk("t4_uncorr_cnt", 32'(uncorr_cnt), 32'd1);

    // 5: six-word stream with out_ready low in cycles 2..4.
    tx = 0; rx = 0; held = '0;
    for (int c = 0; c < 40 && rx < 6; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (tx < 6);
      if (tx < 6) begin
        in_data = wd[tx];
        in_par  = wp[tx];
      end
      #1;
      if (!out_ready) begin
        chk("t5_in_ready_stall", 32'(in_ready), 32'd0);
        if (c == 2) held = out_data;
        else begin
          chk("t5_hold_valid", 32'(out_valid), 32'd1);
          chk("t5_hold_data", 32'(out_data), 32'(held));
        end
      end
      if (out_valid && out_ready) begin
        chk($sformatf("t5_word%0d", rx), 32'(out_data), 32'(wd[rx]));
        chk("t5_clean", {30'd0, out_corr, out_uncorr}, 32'd0);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_all_delivered", 32'(rx), 32'd6);

    // 6: counter saturation at 3 with CNT_W=2, clear priority, reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      send(16'h8000, 5'b00000);
      tick();
    end
    chk("t6_corr_sat", 32'(corr_cnt), 32'd3);
    send(16'h8000, 5'b00000);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t6_clr_corr", 32'(corr_cnt), 32'd0);
    chk("t6_clr_uncorr", 32'(uncorr_cnt), 32'd0);
    send(16'h0000, 5'b11111);
    tick();
    chk("t6_after_clr_uncorr", 32'(uncorr_cnt), 32'd1);
    in_valid = 1'b1; in_data = 16'h8000; in_par = 5'b00000;
    tick(); tick(); tick();
    chk("t6_stream_valid", 32'(out_valid), 32'd1);
    chk("t6_stream_corr_cnt", 32'(corr_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_cnts", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
    tick();
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_drop", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
